// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: the 2-bit FSM
// encoding, the default bit period and the frame data width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd1000;
  localparam int unsigned DATA_BITS            = 32'd8;

  // Start-bit midpoint offset; integer divide so odd and even periods both land mid-bit.
  function automatic logic [15:0] half_period(input int unsigned clks_per_bit);
    return 16'((clks_per_bit - 32'd1) / 32'd2);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer for asynchronous inputs; the reset value
// is chosen by the user so the output starts at the input's idle level.
module sync_2ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronizes the pin, samples each bit at its
// midpoint and hands completed bytes to a one-entry holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          INVERT       = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_re,
  output logic [7:0] o_dout,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_ferr,
  output logic       o_busy
);

  localparam logic [15:0] HALF  = half_period(CLKS_PER_BIT);
  localparam logic [15:0] LAST  = 16'(CLKS_PER_BIT - 32'd1);
  localparam int          IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 32'd1);

  logic                 w_rx_pin;
  logic                 w_s;

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [15:0]          r_count;
  logic [15:0]          w_count_nxt;
  logic [IDX_W-1:0]     r_index;
  logic [IDX_W-1:0]     w_index_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_stop_ok;
  logic                 w_stop_bad;

  logic                 r_done;
  logic                 r_ferr;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_overrun;
  logic [7:0]           r_dout;

  assign w_rx_pin = i_rx ^ INVERT;

  // Post-inversion idle level is 1, so the synchronizer resets high.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (w_rx_pin),
    .o_q     (w_s)
  );

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_count <= 16'd0;
      r_index <= {IDX_W{1'b0}};
      r_shift <= {DATA_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_index <= w_index_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; the timer clears on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_index_nxt = r_index;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_nxt = 16'd0;
        w_index_nxt = {IDX_W{1'b0}};
        if (!w_s) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_count == HALF) begin
          w_count_nxt = 16'd0;
          if (w_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      DATA: begin
        if (r_count == LAST) begin
          w_count_nxt = 16'd0;
          w_shift_nxt = {w_s, r_shift[DATA_BITS-1:1]};
          w_index_nxt = r_index + {{(IDX_W-1){1'b0}}, 1'b1};
          if (r_index == LAST_IDX) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      STOP: begin
        // Leave at the stop-bit midpoint so a back-to-back start edge is not missed.
        if (r_count == LAST) begin
          w_count_nxt = 16'd0;
          w_state_nxt = IDLE;
          if (w_s) begin
            w_stop_ok = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = 16'd0;
        w_index_nxt = {IDX_W{1'b0}};
      end
    endcase
  end

  // Status flags registered from the FSM decisions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_stop_ok;
      r_ferr <= w_stop_bad;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  // Holding register: a completed byte wins over a plain read in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_dout    <= 8'd0;
    end else if (r_done) begin
      if (!r_valid || i_re) begin
        r_dout  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (i_re && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= r_valid;
      r_overrun <= r_overrun;
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
  assign o_ferr    = r_ferr;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (16 clk/bit, 16 clk/bit inverted,
// 5 clk/bit) driven by a bit-by-bit frame generator with hand-computed expectations.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a, rx_b, rx_c;
  logic       re_a, re_b, re_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       valid_a, valid_b, valid_c;
  logic       overrun_a, overrun_b, overrun_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt;
  int vrise;

  uart_rx #(.CLKS_PER_BIT(16), .INVERT(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .i_re(re_a),
    .o_dout(dout_a), .o_valid(valid_a), .o_overrun(overrun_a),
    .o_ferr(ferr_a), .o_busy(busy_a));

  uart_rx #(.CLKS_PER_BIT(16), .INVERT(1'b1)) dut_inv (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .i_re(re_b),
    .o_dout(dout_b), .o_valid(valid_b), .o_overrun(overrun_b),
    .o_ferr(ferr_b), .o_busy(busy_b));

  uart_rx #(.CLKS_PER_BIT(5), .INVERT(1'b0)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_c), .i_re(re_c),
    .o_dout(dout_c), .o_valid(valid_c), .o_overrun(overrun_c),
    .o_ferr(ferr_c), .o_busy(busy_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = dut, 1 = dut_inv (pin driven inverted), 2 = dut5
  task automatic set_in(input int which, input logic rxv, input logic rev);
    case (which)
      0:       begin rx_a = rxv;  re_a = rev; end
      1:       begin rx_b = ~rxv; re_b = rev; end
      default: begin rx_c = rxv;  re_c = rev; end
    endcase
  endtask

  function automatic logic get_valid(input int which);
    case (which)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic get_ferr(input int which);
    case (which)
      0:       return ferr_a;
      1:       return ferr_b;
      default: return ferr_c;
    endcase
  endfunction

  // Drives n_cyc cycles of a frame (idle after bit 9); records ferr cycles and
  // the cycle index at which valid rises (-1 if it does not).
  task automatic send(input int which, input int cpb, input logic [7:0] data,
                      input logic stop_bit, input int re_at, input int n_cyc);
    logic [9:0] frame;
    logic       prev_v;
    logic       b;
    int         bi;
    frame    = {stop_bit, data, 1'b0};
    ferr_cnt = 0;
    vrise    = -1;
    prev_v   = get_valid(which);
    for (int i = 0; i < n_cyc; i++) begin
      bi = i / cpb;
      b  = (bi < 10) ? frame[bi] : 1'b1;
      set_in(which, b, (i == re_at));
      @(posedge clk); #1;
      if (get_ferr(which)) ferr_cnt++;
      if (!prev_v && get_valid(which) && vrise < 0) vrise = i;
      prev_v = get_valid(which);
    end
    set_in(which, 1'b1, 1'b0);
  endtask

  task automatic idle(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(which, 1'b1, 1'b0);
      @(posedge clk); #1;
      if (get_ferr(which)) ferr_cnt++;
    end
  endtask

  task automatic read(input int which);
    set_in(which, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_in(which, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b0; rx_c = 1'b1;
    re_a = 1'b0; re_b = 1'b0; re_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   {31'd0, valid_a},   32'd0);
    check("rst_overrun", {31'd0, overrun_a}, 32'd0);
    check("rst_ferr",    {31'd0, ferr_a},    32'd0);
    check("rst_busy",    {31'd0, busy_a},    32'd0);
    check("rst_dout",    {24'd0, dout_a},    32'd0);
    rst_n = 1'b1;
    idle(0, 3);

    // single byte 0xA5
    send(0, 16, 8'hA5, 1'b1, -1, 160);
    check("a5_latency", vrise,    32'd155);
    check("a5_noferr",  ferr_cnt, 32'd0);
    idle(0, 2);
    check("a5_valid", {31'd0, valid_a}, 32'd1);
    check("a5_dout",  {24'd0, dout_a},  32'h000000A5);
    read(0);
    check("a5_read_valid", {31'd0, valid_a}, 32'd0);

    // glitch: 5 cycles low
    send(0, 16, 8'h00, 1'b1, -1, 5);
    idle(0, 2);
    check("glitch_busy_mid", {31'd0, busy_a}, 32'd1);
    idle(0, 20);
    check("glitch_busy_end", {31'd0, busy_a}, 32'd0);
    check("glitch_valid",    {31'd0, valid_a}, 32'd0);
    check("glitch_noferr",   ferr_cnt, 32'd0);

    // framing error on 0x3C, then good 0x11
    send(0, 16, 8'h3C, 1'b0, -1, 160);
    check("ferr_pulse",   ferr_cnt, 32'd1);
    check("ferr_novalid", vrise,    32'hFFFFFFFF);
    idle(0, 20);
    check("ferr_once",       ferr_cnt, 32'd1);
    check("ferr_valid_after", {31'd0, valid_a}, 32'd0);
    check("ferr_busy_after",  {31'd0, busy_a},  32'd0);
    send(0, 16, 8'h11, 1'b1, -1, 160);
    check("x11_latency", vrise, 32'd155);
    idle(0, 2);
    check("x11_dout", {24'd0, dout_a}, 32'h00000011);
    read(0);

    // overrun on back-to-back 0x01, 0x02
    send(0, 16, 8'h01, 1'b1, -1, 160);
    check("ovr_first_latency", vrise, 32'd155);
    send(0, 16, 8'h02, 1'b1, -1, 160);
    idle(0, 4);
    check("ovr_dout",    {24'd0, dout_a},    32'h00000001);
    check("ovr_valid",   {31'd0, valid_a},   32'd1);
    check("ovr_overrun", {31'd0, overrun_a}, 32'd1);
    read(0);
    check("ovr_read_valid",   {31'd0, valid_a},   32'd0);
    check("ovr_read_overrun", {31'd0, overrun_a}, 32'd0);

    // same, with re in the completion cycle of the second byte
    send(0, 16, 8'h01, 1'b1, -1, 160);
    check("b2b_first_valid", {31'd0, valid_a}, 32'd1);
    send(0, 16, 8'h02, 1'b1, 155, 160);
    idle(0, 4);
    check("b2b_dout",    {24'd0, dout_a},    32'h00000002);
    check("b2b_valid",   {31'd0, valid_a},   32'd1);
    check("b2b_overrun", {31'd0, overrun_a}, 32'd0);

    // reset during data bit 4 of 0xFF
    send(0, 16, 8'hFF, 1'b1, -1, 88);
    check("mid_busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid",   {31'd0, valid_a},   32'd0);
    check("mid_rst_dout",    {24'd0, dout_a},    32'd0);
    check("mid_rst_overrun", {31'd0, overrun_a}, 32'd0);
    check("mid_rst_ferr",    {31'd0, ferr_a},    32'd0);
    check("mid_rst_busy",    {31'd0, busy_a},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, 3);
    send(0, 16, 8'h5A, 1'b1, -1, 160);
    check("x5a_latency", vrise,    32'd155);
    check("x5a_noferr",  ferr_cnt, 32'd0);
    idle(0, 2);
    check("x5a_dout", {24'd0, dout_a}, 32'h0000005A);

    // inverted pin polarity
    send(1, 16, 8'hC3, 1'b1, -1, 160);
    check("inv_latency", vrise,    32'd155);
    check("inv_noferr",  ferr_cnt, 32'd0);
    idle(1, 2);
    check("inv_valid", {31'd0, valid_b}, 32'd1);
    check("inv_dout",  {24'd0, dout_b},  32'h000000C3);

    // 5 clocks per bit (HALF = 2): valid at 9*5+5+1 = 51
    send(2, 5, 8'h96, 1'b1, -1, 55);
    check("cpb5_latency", vrise,    32'd51);
    check("cpb5_noferr",  ferr_cnt, 32'd0);
    check("cpb5_dout",    {24'd0, dout_c}, 32'h00000096);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
